// File: rtl/branch_cmp_serial.sv
// Serial branch-resolution comparator: walks the operands one nibble per cycle,
// MSB nibble first, stopping at the first differing nibble.
module branch_cmp_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       funct3_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             taken_o,
    output logic             equal_o,
    output logic             alarger_o,
    output logic             blarger_o,
    output logic             illegal_o
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0]    IDX_TOP   = IW'(NIB - 1);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [2:0]       funct3_reg, funct3_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             taken_reg, taken_next;
    logic             equal_reg, equal_next;
    logic             alarger_reg, alarger_next;
    logic             blarger_reg, blarger_next;
    logic             illegal_reg, illegal_next;

    logic [3:0] a_nib [NIB];
    logic [3:0] b_nib [NIB];
    logic [3:0] a_cur, b_cur;
    logic       nib_eq, nib_agt, nib_bgt;
    logic       signed_op;
    logic       taken_dec;

    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*4 +: 4];
            assign b_nib[gi] = b_reg[gi*4 +: 4];
        end
    endgenerate

    assign a_cur   = a_nib[idx_reg];
    assign b_cur   = b_nib[idx_reg];
    assign nib_eq  = (a_cur == b_cur);
    assign nib_agt = (a_cur > b_cur);
    assign nib_bgt = (a_cur < b_cur);

    // BLT/BGE: flipping the sign bit turns a signed compare into an unsigned one.
    assign signed_op = (funct3_i[2:1] == 2'b10);

    always_comb begin
        case (funct3_reg)
            3'b000:         taken_dec = nib_eq;
            3'b001:         taken_dec = !nib_eq;
            3'b100, 3'b110: taken_dec = nib_bgt;
            3'b101, 3'b111: taken_dec = nib_eq | nib_agt;
            default:        taken_dec = 1'b0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        funct3_next  = funct3_reg;
        idx_next     = idx_reg;
        taken_next   = taken_reg;
        equal_next   = equal_reg;
        alarger_next = alarger_reg;
        blarger_next = blarger_reg;
        illegal_next = illegal_reg;
        case (state_reg)
            IDLE: begin
                if (!flush_i && req_valid_i) begin
                    a_next      = signed_op ? (a_i ^ SIGN_MASK) : a_i;
                    b_next      = signed_op ? (b_i ^ SIGN_MASK) : b_i;
                    funct3_next = funct3_i;
                    idx_next    = IDX_TOP;
                    state_next  = CMP;
                end
            end
            CMP: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (!nib_eq || idx_reg == '0) begin
                    // Reaching nibble 0 with no difference means the operands are equal.
                    state_next   = DONE;
                    equal_next   = nib_eq;
                    alarger_next = nib_agt;
                    blarger_next = nib_bgt;
                    illegal_next = (funct3_reg[2:1] == 2'b01);
                    taken_next   = taken_dec;
                end else begin
                    idx_next = idx_reg - IW'(1);
                end
            end
            DONE: begin
                if (flush_i || rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            funct3_reg  <= '0;
            idx_reg     <= IDX_TOP;
            taken_reg   <= 1'b0;
            equal_reg   <= 1'b0;
            alarger_reg <= 1'b0;
            blarger_reg <= 1'b0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            funct3_reg  <= funct3_next;
            idx_reg     <= idx_next;
            taken_reg   <= taken_next;
            equal_reg   <= equal_next;
            alarger_reg <= alarger_next;
            blarger_reg <= blarger_next;
            illegal_reg <= illegal_next;
        end
    end

    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == DONE);
    assign taken_o     = taken_reg;
    assign equal_o     = equal_reg;
    assign alarger_o   = alarger_reg;
    assign blarger_o   = blarger_reg;
    assign illegal_o   = illegal_reg;

endmodule

// File: tb/tb_branch_cmp_serial.sv
// Scoreboard bench for branch_cmp_serial: expectations come from a behavioural
// compare model and are popped when each response appears.
module tb_branch_cmp_serial;

    localparam int WIDTH = 32;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       funct3;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             taken;
    logic             equal;
    logic             alarger;
    logic             blarger;
    logic             illegal;

    typedef struct {
        logic [4:0] flags;  // {taken, equal, alarger, blarger, illegal}
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_cmp_serial #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .a_i        (a),
        .b_i        (b),
        .funct3_i   (funct3),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .taken_o    (taken),
        .equal_o    (equal),
        .alarger_o  (alarger),
        .blarger_o  (blarger),
        .illegal_o  (illegal)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic [2:0] f3);
        exp_t e;
        logic eq, al, bl, ill, tk;
        eq = (ma == mb);
        if (f3 == 3'b100 || f3 == 3'b101) begin
            al = ($signed(ma) > $signed(mb));
            bl = ($signed(ma) < $signed(mb));
        end else begin
            al = (ma > mb);
            bl = (ma < mb);
        end
        ill = (f3 == 3'b010 || f3 == 3'b011);
        case (f3)
            3'b000:         tk = eq;
            3'b001:         tk = !eq;
            3'b100, 3'b110: tk = bl;
            3'b101, 3'b111: tk = eq || al;
            default:        tk = 1'b0;
        endcase
        e.flags = {tk, eq, al, bl, ill};
        e.lat   = NIB;
        for (int k = NIB - 1; k >= 0; k--) begin
            if (ma[k*4 +: 4] != mb[k*4 +: 4]) begin
                e.lat = NIB - k;
                break;
            end
        end
        return e;
    endfunction

    // Drives one request through the accept edge, then scrambles the inputs.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [2:0] f3, input bit push);
        int n;
        a = ia; b = ib; funct3 = f3; req_valid = 1'b1;
        if (push) sb.push_back(model(ia, ib, f3));
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = $urandom; b = $urandom; funct3 = 3'($urandom);
    endtask

    task automatic wait_rsp(output int cyc, output bit timeout);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        timeout = !rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        a = '0; b = '0; funct3 = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, taken, equal, alarger, blarger, illegal} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_state: got rdy/vld/flags=%b required 1000000",
                     {req_ready, rsp_valid, taken, equal, alarger, blarger, illegal});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("txn reset done");
    endtask

    task automatic test_compare(input string name, input logic [WIDTH-1:0] ta,
                                input logic [WIDTH-1:0] tb, input logic [2:0] f3);
        exp_t e;
        int   cyc;
        bit   to;
        rsp_ready = 1'b1;
        issue(ta, tb, f3, 1'b1);
        wait_rsp(cyc, to);
        e = sb.pop_front();
        $display("txn %s a=%h b=%h f3=%b lat=%0d flags=%b", name, ta, tb, f3, cyc,
                 {taken, equal, alarger, blarger, illegal});
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1", name, rsp_valid);
        end
        checks++;
        if ({taken, equal, alarger, blarger, illegal} !== e.flags) begin
            errors++;
            $display("FAIL %s_flags: got %b required %b", name,
                     {taken, equal, alarger, blarger, illegal}, e.flags);
        end
        checks++;
        if (cyc != e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, cyc, e.lat);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: got vld=%b rdy=%b required vld=0 rdy=1",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        bit   to;
        rsp_ready = 1'b0;
        issue(32'h0, 32'h1, 3'b001, 1'b1);
        wait_rsp(cyc, to);
        e = sb.pop_front();
        $display("txn backpressure lat=%0d flags=%b", cyc, {taken, equal, alarger, blarger, illegal});
        checks++;
        if (to || cyc != e.lat) begin
            errors++;
            $display("FAIL bp_latency: got %0d (timeout=%0b) required %0d", cyc, to, e.lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
                {taken, equal, alarger, blarger, illegal} !== e.flags) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b flags=%b required vld=1 rdy=0 flags=%b",
                         i, rsp_valid, req_ready, {taken, equal, alarger, blarger, illegal}, e.flags);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b required vld=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        int seen;
        rsp_ready = 1'b1;
        // Flush in IDLE with a pending request must block acceptance.
        flush = 1'b1; req_valid = 1'b1; a = 32'h1; b = 32'h2; funct3 = 3'b000;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle_accept: got rdy=%b required 1", req_ready);
        end
        flush = 1'b0; req_valid = 1'b0;
        issue(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_cmp: got vld=%b rdy=%b required vld=0 rdy=1", rsp_valid, req_ready);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_rsp: got %0d valid cycles required 0", seen);
        end
        $display("txn flush mid-compare");
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(32'h1234_5678, 32'h1234_5678, 3'b000, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, taken, equal, alarger, blarger, illegal} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_mid: got rdy/vld/flags=%b required 1000000",
                     {req_ready, rsp_valid, taken, equal, alarger, blarger, illegal});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got %0d valid cycles required 0", seen);
        end
        $display("txn reset mid-compare");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   to;
        rsp_ready = 1'b1;
        a = 32'hF000_0000; b = 32'h0; funct3 = 3'b001; req_valid = 1'b1;
        sb.push_back(model(a, b, funct3));
        sb.push_back(model(a, b, funct3));
        @(posedge clk); #1;
        for (int t = 0; t < 2; t++) begin
            wait_rsp(cyc, to);
            e = sb.pop_front();
            $display("txn back_to_back%0d lat=%0d flags=%b", t, cyc,
                     {taken, equal, alarger, blarger, illegal});
            checks++;
            if (to || cyc != e.lat || {taken, equal, alarger, blarger, illegal} !== e.flags) begin
                errors++;
                $display("FAIL b2b_rsp%0d: got lat=%0d flags=%b required lat=%0d flags=%b",
                         t, cyc, {taken, equal, alarger, blarger, illegal}, e.lat, e.flags);
            end
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready_done%0d: got rdy=%b required 0", t, req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle%0d: got rdy=%b vld=%b required rdy=1 vld=0",
                         t, req_ready, rsp_valid);
            end
            if (t == 1) req_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb;
        logic [2:0]       f3;
        int               k;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            k  = $urandom_range(NIB, 0);
            rb = ra;
            if (k < NIB) rb[k*4 +: 4] = ra[k*4 +: 4] ^ 4'($urandom_range(15, 1));
            f3 = 3'($urandom);
            test_compare($sformatf("rand%0d", i), ra, rb, f3);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_compare("beq_equal", 32'h1234_5678, 32'h1234_5678, 3'b000);
        test_compare("blt_signed", 32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        test_compare("bltu_unsigned", 32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
        test_compare("bge_signed", 32'h8000_0000, 32'h7FFF_FFFF, 3'b101);
        test_compare("bgeu_nibble1", 32'h0000_0010, 32'h0000_000F, 3'b111);
        test_compare("bne_equal", 32'hCAFE_0000, 32'hCAFE_0000, 3'b001);
        test_backpressure();
        test_compare("illegal_010", 32'h5, 32'h3, 3'b010);
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
